// File: rtl/exu_bpu_rf_rsp.sv
// rtl/exu_bpu_rf_rsp.sv - BPU rs1/x1 responder on the shared RF read port
//
// Serves one-shot rs1 reads for the IFU lite branch predictor (JALR targets)
// over the RF read port. The EXU always has priority on that port. Also keeps
// an x1 shadow copy and a count of dispatched-but-not-written-back x1 writers.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   bpu2rf_rs1_ena    request pulse, bpu_rs1_idx = register to read
//   rf2bpu_rs1        rs1 response data (held between responses)
//   rf2bpu_rs1_vld    response pulse
//   bpu_rs1_busy      request in flight
//   rf2bpu_x1         x1 shadow value
//   bpu_x1_busy       x1 has outstanding writes
//   bpu_req_drop      sticky: request arrived while busy
//   exu_rf_ren        EXU owns the RF read port this cycle
//   rf_ren, rf_ridx   BPU-side RF read request
//   rf_rdata          RF read data, one cycle after rf_ren
//   disp_*            dispatch info for x1 writer tracking
//   wb_*              RF writeback strobe/index/data
//   flush             aborts any in-flight rs1 read

module exu_bpu_rf_rsp #(
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5,
    parameter int X1CNT_W     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bpu2rf_rs1_ena,
    input  logic [RFIDX_WIDTH-1:0] bpu_rs1_idx,
    output logic [XLEN-1:0]        rf2bpu_rs1,
    output logic                   rf2bpu_rs1_vld,
    output logic                   bpu_rs1_busy,
    output logic [XLEN-1:0]        rf2bpu_x1,
    output logic                   bpu_x1_busy,
    output logic                   bpu_req_drop,
    input  logic                   exu_rf_ren,
    output logic                   rf_ren,
    output logic [RFIDX_WIDTH-1:0] rf_ridx,
    input  logic [XLEN-1:0]        rf_rdata,
    input  logic                   disp_ena,
    input  logic                   disp_rdwen,
    input  logic [RFIDX_WIDTH-1:0] disp_rdidx,
    input  logic                   wb_ena,
    input  logic [RFIDX_WIDTH-1:0] wb_idx,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   flush
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_READ = 2'd2
    } state_t;

    localparam logic [RFIDX_WIDTH-1:0] IDX_X0  = '0;
    localparam logic [RFIDX_WIDTH-1:0] IDX_X1  = RFIDX_WIDTH'(1);
    localparam logic [X1CNT_W-1:0]     CNT_MAX = '1;

    state_t                 state_q;
    logic [RFIDX_WIDTH-1:0] idx_q;
    logic [XLEN-1:0]        rs1_q;
    logic                   zero_vld_q;
    logic                   drop_q;
    logic [XLEN-1:0]        x1_q;
    logic [X1CNT_W-1:0]     cnt_q;

    logic                   rd_hit;
    logic                   wb_bypass;
    logic [XLEN-1:0]        rd_data;
    logic                   x1_inc;
    logic                   x1_dec;

    // RF data only exists in the READ cycle, so the response is presented
    // combinationally there and registered for holding afterwards. A same-
    // cycle writeback to the latched index wins over the (stale) port data.
    always_comb begin
        rd_hit         = (state_q == S_READ) && !flush;
        wb_bypass      = wb_ena && (wb_idx == idx_q) && (wb_idx != IDX_X0);
        rd_data        = wb_bypass ? wb_data : rf_rdata;
        rf2bpu_rs1     = rd_hit ? rd_data : rs1_q;
        rf2bpu_rs1_vld = rd_hit || zero_vld_q;
        bpu_rs1_busy   = (state_q != S_IDLE);
        rf_ren         = (state_q == S_ARB) && !exu_rf_ren;
        rf_ridx        = idx_q;
        bpu_req_drop   = drop_q;
        rf2bpu_x1      = x1_q;
        bpu_x1_busy    = (cnt_q != '0);
    end

    // rs1 request FSM. A flush wins over everything, including a request
    // arriving in the same cycle (which is silently discarded).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            rs1_q      <= '0;
            zero_vld_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            zero_vld_q <= 1'b0;
            if (flush) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bpu2rf_rs1_ena) begin
                            if (bpu_rs1_idx != IDX_X0) begin
                                idx_q   <= bpu_rs1_idx;
                                state_q <= S_ARB;
                            end else begin
                                // x0 reads need no port access
                                rs1_q      <= '0;
                                zero_vld_q <= 1'b1;
                            end
                        end
                    end
                    S_ARB: begin
                        if (!exu_rf_ren) begin
                            state_q <= S_READ;
                        end
                        if (bpu2rf_rs1_ena) begin
                            drop_q <= 1'b1;
                        end
                    end
                    S_READ: begin
                        rs1_q   <= rd_data;
                        state_q <= S_IDLE;
                        if (bpu2rf_rs1_ena) begin
                            drop_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // x1 shadow and pending-writer count. Flush leaves the count alone:
    // flushed writers are still retired through the writeback path.
    always_comb begin
        x1_inc = disp_ena && disp_rdwen && (disp_rdidx == IDX_X1);
        x1_dec = wb_ena && (wb_idx == IDX_X1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x1_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (x1_dec) begin
                x1_q <= wb_data;
            end
            if (x1_inc && !x1_dec && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + X1CNT_W'(1);
            end else if (x1_dec && !x1_inc && (cnt_q != '0)) begin
                cnt_q <= cnt_q - X1CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_exu_bpu_rf_rsp.sv
// tb/tb_exu_bpu_rf_rsp.sv - testbench for exu_bpu_rf_rsp

module tb_exu_bpu_rf_rsp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bpu2rf_rs1_ena = 1'b0;
    logic [4:0]  bpu_rs1_idx = '0;
    logic [31:0] rf2bpu_rs1;
    logic        rf2bpu_rs1_vld;
    logic        bpu_rs1_busy;
    logic [31:0] rf2bpu_x1;
    logic        bpu_x1_busy;
    logic        bpu_req_drop;
    logic        exu_rf_ren = 1'b0;
    logic        rf_ren;
    logic [4:0]  rf_ridx;
    logic [31:0] rf_rdata = '0;
    logic        disp_ena = 1'b0;
    logic        disp_rdwen = 1'b0;
    logic [4:0]  disp_rdidx = '0;
    logic        wb_ena = 1'b0;
    logic [4:0]  wb_idx = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;

    exu_bpu_rf_rsp dut (
        .clk(clk), .rst(rst),
        .bpu2rf_rs1_ena(bpu2rf_rs1_ena), .bpu_rs1_idx(bpu_rs1_idx),
        .rf2bpu_rs1(rf2bpu_rs1), .rf2bpu_rs1_vld(rf2bpu_rs1_vld),
        .bpu_rs1_busy(bpu_rs1_busy), .rf2bpu_x1(rf2bpu_x1),
        .bpu_x1_busy(bpu_x1_busy), .bpu_req_drop(bpu_req_drop),
        .exu_rf_ren(exu_rf_ren), .rf_ren(rf_ren), .rf_ridx(rf_ridx),
        .rf_rdata(rf_rdata), .disp_ena(disp_ena), .disp_rdwen(disp_rdwen),
        .disp_rdidx(disp_rdidx), .wb_ena(wb_ena), .wb_idx(wb_idx),
        .wb_data(wb_data), .flush(flush)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] rf_mem [32];
    always @(posedge clk) if (rf_ren) rf_rdata <= rf_mem[rf_ridx];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } sb_t;
    sb_t sb_q[$];

    always @(negedge clk) begin
        if (!rst && rf2bpu_rs1_vld) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_vld", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("rs1_data", rf2bpu_rs1, e.data);
                chk("rs1_latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] rf_val;
        int          hold;
        bit          wb_en;
        logic [4:0]  wb_idx;
        logic [31:0] wb_val;
        logic [31:0] exp_data;
        int          lat;
    } vec_t;
    vec_t vt[6];
    logic [31:0] last_rs1 = '0;

    task automatic run_vec(input vec_t v);
        if (v.idx != 0) rf_mem[v.idx] = v.rf_val;
        tick;
        bpu2rf_rs1_ena = 1'b1;
        bpu_rs1_idx    = v.idx;
        exu_rf_ren     = 1'b0;
        sb_q.push_back('{v.exp_data, cyc + v.lat});
        for (int k = 1; k <= v.lat + 1; k++) begin
            tick;
            bpu2rf_rs1_ena = 1'b0;
            exu_rf_ren     = (k <= v.hold);
            wb_ena         = v.wb_en && (k == v.lat);
            wb_idx         = v.wb_idx;
            wb_data        = v.wb_val;
            @(negedge clk);
            chk("vec_rf_ren", {31'd0, rf_ren}, {31'd0, (v.idx != 0) && (k == v.hold + 1)});
            chk("vec_busy", {31'd0, bpu_rs1_busy}, {31'd0, (v.idx != 0) && (k <= v.lat)});
        end
        wb_ena     = 1'b0;
        exu_rf_ren = 1'b0;
        last_rs1   = v.exp_data;
    endtask

    task automatic drive_x1(input bit d, input bit w, input logic [31:0] data);
        tick;
        disp_ena   = d;
        disp_rdwen = d;
        disp_rdidx = 5'd1;
        wb_ena     = w;
        wb_idx     = 5'd1;
        wb_data    = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0BAD_0000 + i;
        vt[0] = '{5'd5,  32'hDEADBEEF, 0, 1'b0, 5'd0,  32'h0,    32'hDEADBEEF, 2};
        vt[1] = '{5'd7,  32'h7777_0007, 3, 1'b0, 5'd0,  32'h0,    32'h7777_0007, 5};
        vt[2] = '{5'd9,  32'h0000_0BAD, 0, 1'b1, 5'd9,  32'h1234, 32'h0000_1234, 2};
        vt[3] = '{5'd0,  32'hFFFF_FFFF, 0, 1'b0, 5'd0,  32'h0,    32'h0,         1};
        vt[4] = '{5'd31, 32'hA5A5_5A5A, 1, 1'b0, 5'd0,  32'h0,    32'hA5A5_5A5A, 3};
        vt[5] = '{5'd3,  32'h3333_0003, 0, 1'b1, 5'd10, 32'h5555, 32'h3333_0003, 2};

        // reset and idle
        repeat (3) tick;
        rst = 1'b0;
        repeat (3) tick;
        @(negedge clk);
        chk("rst_rs1", rf2bpu_rs1, 32'h0);
        chk("rst_vld", {31'd0, rf2bpu_rs1_vld}, 32'd0);
        chk("rst_busy", {31'd0, bpu_rs1_busy}, 32'd0);
        chk("rst_x1", rf2bpu_x1, 32'h0);
        chk("rst_x1_busy", {31'd0, bpu_x1_busy}, 32'd0);
        chk("rst_drop", {31'd0, bpu_req_drop}, 32'd0);
        chk("rst_rf_ren", {31'd0, rf_ren}, 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vt[i]);
        chk("vec_drop_clear", {31'd0, bpu_req_drop}, 32'd0);

        // x1 tracking: two writers, then wb with simultaneous dispatch
        drive_x1(1, 0, 0);
        drive_x1(1, 0, 0);
        drive_x1(1, 1, 32'h8000_0010);
        @(negedge clk);
        chk("x1_busy_2", {31'd0, bpu_x1_busy}, 32'd1);
        drive_x1(0, 0, 0);
        @(negedge clk);
        chk("x1_shadow_a", rf2bpu_x1, 32'h8000_0010);
        chk("x1_busy_held", {31'd0, bpu_x1_busy}, 32'd1);
        drive_x1(0, 1, 32'h0000_0011);
        drive_x1(0, 0, 0);
        @(negedge clk);
        chk("x1_busy_1", {31'd0, bpu_x1_busy}, 32'd1);
        drive_x1(0, 1, 32'h0000_0022);
        drive_x1(0, 0, 0);
        @(negedge clk);
        chk("x1_busy_0", {31'd0, bpu_x1_busy}, 32'd0);
        chk("x1_shadow_last", rf2bpu_x1, 32'h0000_0022);

        // non-x1 or non-writing dispatches do not count
        tick;
        disp_ena = 1'b1; disp_rdwen = 1'b1; disp_rdidx = 5'd2;
        tick;
        disp_rdwen = 1'b0; disp_rdidx = 5'd1;
        tick;
        disp_ena = 1'b0;
        @(negedge clk);
        chk("x1_other_disp", {31'd0, bpu_x1_busy}, 32'd0);

        // saturation at 7, then retire 7
        for (int i = 0; i < 9; i++) drive_x1(1, 0, 0);
        for (int i = 0; i < 6; i++) drive_x1(0, 1, 32'h100 + i);
        drive_x1(0, 0, 0);
        @(negedge clk);
        chk("x1_sat_busy", {31'd0, bpu_x1_busy}, 32'd1);
        drive_x1(0, 1, 32'hCAFE_0007);
        drive_x1(0, 0, 0);
        @(negedge clk);
        chk("x1_sat_drain", {31'd0, bpu_x1_busy}, 32'd0);
        chk("x1_sat_shadow", rf2bpu_x1, 32'hCAFE_0007);
        // decrement at zero must hold zero
        drive_x1(0, 1, 32'hCAFE_0008);
        drive_x1(1, 0, 0);
        drive_x1(0, 0, 0);
        @(negedge clk);
        chk("x1_underflow_busy", {31'd0, bpu_x1_busy}, 32'd1);
        drive_x1(0, 1, 32'hCAFE_0009);
        drive_x1(0, 0, 0);
        @(negedge clk);
        chk("x1_underflow_drain", {31'd0, bpu_x1_busy}, 32'd0);

        // request coincident with flush in IDLE: dropped, no drop flag
        tick;
        bpu2rf_rs1_ena = 1'b1; bpu_rs1_idx = 5'd6; flush = 1'b1;
        tick;
        bpu2rf_rs1_ena = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_req_busy", {31'd0, bpu_rs1_busy}, 32'd0);
        chk("flush_req_drop", {31'd0, bpu_req_drop}, 32'd0);

        // flush in READ: no response, held data unchanged
        rf_mem[8] = 32'h8888_0008;
        tick;
        bpu2rf_rs1_ena = 1'b1; bpu_rs1_idx = 5'd8;
        tick;
        bpu2rf_rs1_ena = 1'b0;
        tick;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_read_busy", {31'd0, bpu_rs1_busy}, 32'd1);
        chk("flush_read_vld", {31'd0, rf2bpu_rs1_vld}, 32'd0);
        chk("flush_read_rs1", rf2bpu_rs1, last_rs1);
        tick;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_read_idle", {31'd0, bpu_rs1_busy}, 32'd0);
        chk("flush_read_hold", rf2bpu_rs1, last_rs1);

        // second request while busy, then flush in ARB
        tick;
        bpu2rf_rs1_ena = 1'b1; bpu_rs1_idx = 5'd4;
        tick;
        exu_rf_ren = 1'b1;
        @(negedge clk);
        chk("drop_busy", {31'd0, bpu_rs1_busy}, 32'd1);
        tick;
        bpu2rf_rs1_ena = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("drop_sticky_set", {31'd0, bpu_req_drop}, 32'd1);
        tick;
        flush = 1'b0; exu_rf_ren = 1'b0;
        @(negedge clk);
        chk("drop_flush_idle", {31'd0, bpu_rs1_busy}, 32'd0);
        chk("drop_flush_rf_ren", {31'd0, rf_ren}, 32'd0);
        tick;
        @(negedge clk);
        chk("drop_still_idle", {31'd0, bpu_rs1_busy}, 32'd0);

        // x0 read after the flush
        tick;
        bpu2rf_rs1_ena = 1'b1; bpu_rs1_idx = 5'd0;
        sb_q.push_back('{32'h0, cyc + 1});
        tick;
        bpu2rf_rs1_ena = 1'b0;
        @(negedge clk);
        chk("x0_vld", {31'd0, rf2bpu_rs1_vld}, 32'd1);
        tick;
        @(negedge clk);
        chk("drop_sticky_hold", {31'd0, bpu_req_drop}, 32'd1);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
